// File: rtl/pose_sequencer.sv
// pose_sequencer: writable pose table with a timed playback FSM that feeds the PWM generators
module pose_sequencer #(
  parameter int NUM_SERVOS = 3,
  parameter int POS_W      = 8,
  parameter int TIME_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int TICK_DIV   = 1000000
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              START,
  input  logic                              STOP,
  input  logic                              LOOP,
  input  logic [ADDR_W-1:0]                 BASE_ADDR,
  input  logic                              WR_EN,
  input  logic [ADDR_W-1:0]                 WR_ADDR,
  input  logic [NUM_SERVOS*POS_W+TIME_W-1:0] WR_DATA,
  output logic [NUM_SERVOS*POS_W-1:0]       POS,
  output logic [ADDR_W-1:0]                 STEP_ADDR,
  output logic                              BUSY,
  output logic                              DONE
);
  localparam int EW = NUM_SERVOS*POS_W+TIME_W;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV-1);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, HOLD} state_t;
  state_t state, state_n;
  logic [EW-1:0] mem [2**ADDR_W];
  logic [EW-1:0] rd;
  logic [TIME_W-1:0] hold_t, tick, tick_n;
  logic [PW-1:0] presc, presc_n;
  logic [NUM_SERVOS*POS_W-1:0] pos_n;
  logic [ADDR_W-1:0] addr_n;
  logic done_n;
  assign hold_t = rd[TIME_W-1:0];
  // writes are gated by reset too, so a strobe held through reset cannot corrupt the table
  always_ff @(posedge CLK) begin
    if (RST_N && WR_EN && state == IDLE) mem[WR_ADDR] <= WR_DATA;
    if (state == FETCH) rd <= mem[STEP_ADDR];
  end
  always_comb begin
    state_n = state;
    addr_n  = STEP_ADDR;
    pos_n   = POS;
    presc_n = presc;
    tick_n  = tick;
    done_n  = 1'b0;
    if (state != IDLE && STOP) state_n = IDLE;
    else
      case (state)
        IDLE:
          if (START && !STOP) begin
            state_n = FETCH;
            addr_n  = BASE_ADDR;
          end
        FETCH: state_n = LOAD;
        LOAD:
          if (hold_t != '0) begin
            state_n = HOLD;
            pos_n   = rd[EW-1:TIME_W];
            presc_n = '0;
            tick_n  = '0;
          end else if (LOOP && STEP_ADDR != BASE_ADDR) begin
            state_n = FETCH;
            addr_n  = BASE_ADDR;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        HOLD:
          if (presc != PMAX) presc_n = presc + PW'(1);
          else begin
            presc_n = '0;
            tick_n  = tick + TIME_W'(1);
            if (tick_n == hold_t) begin
              state_n = FETCH;
              addr_n  = STEP_ADDR + ADDR_W'(1);
            end
          end
      endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      POS       <= '0;
      STEP_ADDR <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      presc     <= '0;
      tick      <= '0;
    end else begin
      state     <= state_n;
      POS       <= pos_n;
      STEP_ADDR <= addr_n;
      BUSY      <= state_n != IDLE;
      DONE      <= done_n;
      presc     <= presc_n;
      tick      <= tick_n;
    end
  end
endmodule

// File: tb/tb_pose_sequencer.sv
// tb_pose_sequencer: randomized playback against a timeline model, scoreboarded by a pose/done monitor
module tb_pose_sequencer;
  localparam int TD = 4;
  typedef struct {int cyc; bit done; logic [23:0] pos; logic [7:0] addr;} ev_t;
  logic CLK = 1'b0, RST_N = 1'b0, START = 1'b0, STOP = 1'b0, LOOP = 1'b0, WR_EN = 1'b0;
  logic [7:0] BASE_ADDR = '0, WR_ADDR = '0;
  logic [31:0] WR_DATA = '0;
  logic [23:0] POS;
  logic [7:0] STEP_ADDR;
  logic BUSY, DONE;
  ev_t sb[$];
  ev_t me;
  logic [31:0] tbl [256];
  logic [23:0] model_pos = '0, prev_pos = '0;
  int cyc = 0, errors = 0, checks = 0;

  pose_sequencer #(.NUM_SERVOS(3), .POS_W(8), .TIME_W(8), .ADDR_W(8), .TICK_DIV(TD)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .LOOP(LOOP), .BASE_ADDR(BASE_ADDR),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .POS(POS), .STEP_ADDR(STEP_ADDR),
    .BUSY(BUSY), .DONE(DONE));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // a visible event is any pose change or a DONE pulse
  always @(negedge CLK) begin
    if (RST_N && (DONE || POS !== prev_pos)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d done=%0b pos=%h addr=%0d", cyc, DONE, POS, STEP_ADDR);
      end else begin
        me = sb.pop_front();
        if (me.cyc != cyc || me.done !== DONE || me.pos !== POS || me.addr !== STEP_ADDR) begin
          errors++;
          $display("FAIL event got cyc=%0d done=%0b pos=%h addr=%0d expected cyc=%0d done=%0b pos=%h addr=%0d",
                   cyc, DONE, POS, STEP_ADDR, me.cyc, me.done, me.pos, me.addr);
        end
      end
    end
    prev_pos = POS;
  end

  function automatic logic [31:0] ent(input int p0, input int p1, input int p2, input int t);
    return {p2[7:0], p1[7:0], p0[7:0], t[7:0]};
  endfunction

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    step;
    WR_EN = 1'b0;
    tbl[a] = d;
  endtask

  // stop_rel: edge (after the START edge) at which STOP is sampled; wr_rel: edge of an ignored write (0 = none)
  task automatic run(input logic [7:0] base, input bit loop, input int stop_rel, input int wr_rel);
    int e0, s, t, c, endc;
    logic [7:0] a;
    logic [23:0] cur;
    logic [31:0] en;
    bit fin;
    e0 = cyc + 1; s = e0 + stop_rel; t = e0; a = base; cur = model_pos; endc = s; fin = 0;
    while (!fin) begin
      c = t + 2;
      if (c >= s) fin = 1;
      else begin
        en = tbl[a];
        if (en[7:0] != 0) begin
          if (en[31:8] != cur) sb.push_back('{c, 1'b0, en[31:8], a});
          cur = en[31:8];
          t = c + int'(en[7:0]) * TD;
          a++;
        end else if (loop && a != base) begin
          a = base;
          t = c;
        end else begin
          sb.push_back('{c, 1'b1, cur, a});
          endc = c;
          fin = 1;
        end
      end
    end
    model_pos = cur;
    START = 1'b1; BASE_ADDR = base; LOOP = loop;
    step;
    START = 1'b0;
    for (int n = e0 + 1; n <= endc; n++) begin
      STOP = (n == s);
      WR_EN = (n == e0 + wr_rel);
      WR_ADDR = base;
      WR_DATA = $urandom;
      step;
    end
    STOP = 1'b0; WR_EN = 1'b0;
    chk("busy_at_end", {31'd0, BUSY}, 32'd0);
    step;
    step;
    chk("scoreboard_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    logic [31:0] r;
    step;
    step;
    RST_N = 1'b1;
    chk("rst_pos", {8'd0, POS}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_step_addr", {24'd0, STEP_ADDR}, 32'd0);
    for (int i = 0; i < 256; i++) wr(8'(i), 32'd0);
    wr(8'd0, ent(60, 0, 0, 2));
    wr(8'd1, ent(120, 0, 0, 1));
    wr(8'd2, ent(0, 0, 0, 0));
    run(8'd0, 1'b0, 1000, 0);
    RST_N = 1'b0; START = 1'b1; WR_EN = 1'b1; WR_ADDR = 8'd0; WR_DATA = ent(99, 99, 99, 7);
    step;
    step;
    RST_N = 1'b1; START = 1'b0; WR_EN = 1'b0;
    model_pos = '0;
    chk("rst2_pos", {8'd0, POS}, 32'd0);
    chk("rst2_busy", {31'd0, BUSY}, 32'd0);
    chk("rst2_done", {31'd0, DONE}, 32'd0);
    chk("rst2_step_addr", {24'd0, STEP_ADDR}, 32'd0);
    run(8'd0, 1'b0, 1000, 0);
    run(8'd0, 1'b1, 40, 2);
    run(8'd0, 1'b0, 14, 13);
    chk("pos_after_stop", {8'd0, POS}, 32'd120);
    START = 1'b1; STOP = 1'b1;
    step;
    START = 1'b0; STOP = 1'b0;
    chk("start_stop_busy", {31'd0, BUSY}, 32'd0);
    step;
    chk("start_stop_busy2", {31'd0, BUSY}, 32'd0);
    wr(8'd5, ent(1, 2, 3, 0));
    run(8'd5, 1'b1, 1000, 1);
    run(8'd0, 1'b0, 1000, 0);
    wr(8'd255, ent(30, 40, 50, 1));
    wr(8'd0, ent(10, 20, 30, 1));
    wr(8'd1, ent(0, 0, 0, 0));
    run(8'd255, 1'b0, 1000, 1);
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 4)) begin
        r = $urandom;
        r[7:0] = ($urandom_range(0, 9) < 3) ? 8'd0 : 8'($urandom_range(1, 3));
        wr(8'($urandom_range(0, 15)), r);
      end
      run(8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 150)), int'($urandom_range(0, 5)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
